mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset; clock clk.
REQ-003 instr  input  32  current instruction from the external IR; stable from DECODE until the instruction retires.
REQ-004 state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-005 ir_we  output  1  IR load strobe.
REQ-006 pc_we  output  1  PC update strobe to the fetch unit.
REQ-007 npc_sel  output  3  next-PC select: 0 PC+4, 1 beq (fetch unit applies cmp), 2 jr, 3 j/jal.
REQ-008 reg_we  output  1  GRF write strobe.
REQ-009 reg_dst  output  2  GRF write address select: 0 rt, 1 rd, 2 $31.
REQ-010 wd_sel  output  2  GRF write data select: 0 ALU, 1 memory, 2 PC+4, 3 {imm16,16'b0}.
REQ-011 alu_src  output  1  ALU B operand: 0 rt, 1 extended imm.
REQ-012 ext_op  output  1  immediate extension: 0 zero, 1 sign.
REQ-013 alu_op  output  2  ALU operation: 0 add, 1 sub, 2 or.
REQ-014 mem_we  output  1  data memory write strobe.
REQ-015 illegal  output  1  sticky flag, set on the first unsupported instruction.

Function
REQ-016 The block SHALL be a Moore FSM; all outputs SHALL decode from state and instr; every strobe not listed for a state SHALL be 0.
REQ-017 FETCH SHALL assert ir_we=1 and go to DECODE unconditionally.
REQ-018 Supported instructions and state paths:
- addu, subu (op 0, funct 0x21/0x23): F,D,E,WB
- ori (0x0D): F,D,E,WB
- lui (0x0F): F,D,WB
- lw (0x23): F,D,E,M,WB
- sw (0x2B): F,D,E,M
- beq (0x04): F,D,E
- j (0x02), jal (0x03): j F,D; jal F,D,WB
- jr (op 0, funct 0x08): F,D
- nop (instr==0): F,D
REQ-019 EXEC SHALL drive ALU controls:
- addu: alu_op=0
- subu, beq: alu_op=1
- ori: alu_op=2, alu_src=1, ext_op=0
- lw, sw: alu_op=0, alu_src=1, ext_op=1
REQ-020 MEM SHALL hold the EXEC ALU controls; sw SHALL assert mem_we=1 in MEM only.
REQ-021 WB SHALL assert reg_we=1:
- addu/subu: reg_dst=1, wd_sel=0
- ori: reg_dst=0, wd_sel=0
- lw: reg_dst=0, wd_sel=1
- lui: reg_dst=0, wd_sel=3
- jal: reg_dst=2, wd_sel=2
REQ-022 pc_we SHALL be 1 for exactly one cycle per instruction, in its final state, which SHALL then go to FETCH; npc_sel SHALL be 3 for j/jal, 2 for jr, 1 for beq, 0 otherwise.
REQ-023 PC SHALL NOT change before the final state, so PC+4 seen in WB belongs to the executing instruction.
REQ-024 An unsupported opcode/funct SHALL set illegal in DECODE and retire as nop; illegal SHALL stay set until reset.
REQ-025 Latency: 2 cycles (j, jr, nop), 3 (beq, lui, jal), 4 (R-type, ori, sw), 5 (lw).

Reset
REQ-026 In any cycle with reset=1 the next state SHALL be FETCH and illegal SHALL clear; no write strobes (pc_we, reg_we, mem_we) SHALL be asserted in that cycle, and an interrupted instruction SHALL be abandoned without side effects.
REQ-027 From the first cycle after reset: state=0, ir_we=1, all other outputs 0.

Configuration
REQ-028 With MC_CTRL_STATS_EN defined, outputs cycle_cnt[31:0] and instret_cnt[31:0] SHALL exist:
- cycle_cnt +1 every non-reset cycle
- instret_cnt +1 on every pc_we
- both cleared by reset, wrap at 2^32
REQ-029 Without MC_CTRL_STATS_EN those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 addu (0x00851021) after reset -> states 0,1,2,4; WB: reg_we=1, reg_dst=1, wd_sel=0, pc_we=1, npc_sel=0.
REQ-031 lw (0x8C850004) -> states 0,1,2,3,4; MEM: alu_src=1, ext_op=1, mem_we=0; WB: wd_sel=1.
REQ-032 jal (0x0C000C00) -> states 0,1,4; WB: reg_dst=2, wd_sel=2, npc_sel=3, pc_we=1; then state=0.
REQ-033 sw (0xAC850008) with reset high in MEM -> mem_we=0 that cycle; next state FETCH.
REQ-034 instr=0xFC000000 -> illegal=1 from the cycle after DECODE; retires in 2 cycles; illegal still 1 after a later addu; cleared only by reset.
REQ-035 With MC_CTRL_STATS_EN: run j, beq, lw -> instret_cnt=3, cycle_cnt=10.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the datapath.
// The controller side takes the master modport, the datapath side the slave modport.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic [2:0]  state;
  logic        ir_we;
  logic        pc_we;
  logic [2:0]  npc_sel;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic        ext_op;
  logic [1:0]  alu_op;
  logic        mem_we;
  logic        illegal;

  modport master (
    input  instr,
    output state, ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel,
           alu_src, ext_op, alu_op, mem_we, illegal
  );

  modport slave (
    output instr,
    input  state, ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel,
           alu_src, ext_op, alu_op, mem_we, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: Moore FSM FETCH/DECODE/EXEC/MEM/WB.
// Optional MC_CTRL_STATS_EN adds cycle_cnt / instret_cnt counters.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  mc_ctrl_if.master   bus
`ifdef MC_CTRL_STATS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t      state_q;
  state_t      state_d;
  logic        illegal_q;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic        is_beq, is_j, is_jal, is_nop, supported;

  logic        final_st;
  logic        ir_we, pc_we, reg_we, alu_src, ext_op, mem_we;
  logic [2:0]  npc_sel;
  logic [1:0]  reg_dst, wd_sel, alu_op;

  // Instruction classification; instr==0 is the only op-0/funct-0 encoding accepted
  always_comb begin
    op        = bus.instr[31:26];
    funct     = bus.instr[5:0];
    is_nop    = (bus.instr == 32'd0);
    is_addu   = (op == OP_RTYPE) && (funct == FN_ADDU);
    is_subu   = (op == OP_RTYPE) && (funct == FN_SUBU);
    is_jr     = (op == OP_RTYPE) && (funct == FN_JR);
    is_ori    = (op == OP_ORI);
    is_lui    = (op == OP_LUI);
    is_lw     = (op == OP_LW);
    is_sw     = (op == OP_SW);
    is_beq    = (op == OP_BEQ);
    is_j      = (op == OP_J);
    is_jal    = (op == OP_JAL);
    supported = is_nop | is_addu | is_subu | is_jr | is_ori | is_lui |
                is_lw | is_sw | is_beq | is_j | is_jal;
  end

  // Unsupported instructions leave DECODE straight to FETCH, retiring like a nop
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_addu | is_subu | is_ori | is_lw | is_sw | is_beq)
          state_d = S_EXEC;
        else if (is_lui | is_jal)
          state_d = S_WB;
        else
          state_d = S_FETCH;
      end
      S_EXEC: begin
        if (is_lw | is_sw)
          state_d = S_MEM;
        else if (is_beq)
          state_d = S_FETCH;
        else
          state_d = S_WB;
      end
      S_MEM:    state_d = is_lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && !supported)
        illegal_q <= 1'b1;
    end
  end

  // Outputs decode from the current state and the held instruction; the PC
  // only moves in an instruction's final state so WB still sees its own PC+4
  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = 3'd0;
    reg_we   = 1'b0;
    reg_dst  = 2'd0;
    wd_sel   = 2'd0;
    alu_src  = 1'b0;
    ext_op   = 1'b0;
    alu_op   = 2'd0;
    mem_we   = 1'b0;
    final_st = 1'b0;
    case (state_q)
      S_FETCH:  ir_we = 1'b1;
      S_DECODE: final_st = is_j | is_jr | is_nop | !supported;
      S_EXEC, S_MEM: begin
        if (is_subu | is_beq) begin
          alu_op = 2'd1;
        end else if (is_ori) begin
          alu_op  = 2'd2;
          alu_src = 1'b1;
        end else if (is_lw | is_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end
        if (state_q == S_EXEC) begin
          final_st = is_beq;
        end else begin
          mem_we   = is_sw;
          final_st = is_sw;
        end
      end
      S_WB: begin
        final_st = 1'b1;
        reg_we   = 1'b1;
        if (is_addu | is_subu) begin
          reg_dst = 2'd1;
        end else if (is_lw) begin
          wd_sel = 2'd1;
        end else if (is_lui) begin
          wd_sel = 2'd3;
        end else if (is_jal) begin
          reg_dst = 2'd2;
          wd_sel  = 2'd2;
        end
      end
      default: ;
    endcase
    if (final_st) begin
      pc_we = 1'b1;
      if (is_j | is_jal)
        npc_sel = 3'd3;
      else if (is_jr)
        npc_sel = 3'd2;
      else if (is_beq)
        npc_sel = 3'd1;
    end
    // A reset cycle abandons the instruction: no architectural writes
    if (reset) begin
      pc_we  = 1'b0;
      reg_we = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign bus.state   = state_q;
  assign bus.ir_we   = ir_we;
  assign bus.pc_we   = pc_we;
  assign bus.npc_sel = npc_sel;
  assign bus.reg_we  = reg_we;
  assign bus.reg_dst = reg_dst;
  assign bus.wd_sel  = wd_sel;
  assign bus.alu_src = alu_src;
  assign bus.ext_op  = ext_op;
  assign bus.alu_op  = alu_op;
  assign bus.mem_we  = mem_we;
  assign bus.illegal = illegal_q;

`ifdef MC_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction reference model from the
// instruction path/control tables, random instruction stream, plus literal pins.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_we;
    logic       pc_we;
    logic [2:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic       ext_op;
    logic [1:0] alu_op;
    logic       mem_we;
    logic       illegal;
  } out_t;

  typedef enum int {
    K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_NOP, K_ILL
  } kind_t;

  logic clk = 1'b0;
  logic reset;

  mc_ctrl_if bus ();

`ifdef MC_CTRL_STATS_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master),
               .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt));
`else
  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          exp_valid = 1'b0;
  bit          exp_rst   = 1'b0;
  out_t        exp_out;
  bit          model_illegal = 1'b0;
  int unsigned model_cyc = 0;
  int unsigned model_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.state   = bus.state;
    o.ir_we   = bus.ir_we;
    o.pc_we   = bus.pc_we;
    o.npc_sel = bus.npc_sel;
    o.reg_we  = bus.reg_we;
    o.reg_dst = bus.reg_dst;
    o.wd_sel  = bus.wd_sel;
    o.alu_src = bus.alu_src;
    o.ext_op  = bus.ext_op;
    o.alu_op  = bus.alu_op;
    o.mem_we  = bus.mem_we;
    o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic kind_t classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (ins == 32'd0) return K_NOP;
    case (op)
      6'h00: begin
        if (fn == 6'h21) return K_ADDU;
        if (fn == 6'h23) return K_SUBU;
        if (fn == 6'h08) return K_JR;
        return K_ILL;
      end
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // State visited on each cycle of the instruction, last entry is the final state
  task automatic path_of(input kind_t k, output int n, output int p[5]);
    case (k)
      K_ADDU, K_SUBU, K_ORI: begin p = '{0, 1, 2, 4, 0}; n = 4; end
      K_LUI, K_JAL:          begin p = '{0, 1, 4, 0, 0}; n = 3; end
      K_LW:                  begin p = '{0, 1, 2, 3, 4}; n = 5; end
      K_SW:                  begin p = '{0, 1, 2, 3, 0}; n = 4; end
      K_BEQ:                 begin p = '{0, 1, 2, 0, 0}; n = 3; end
      default:               begin p = '{0, 1, 0, 0, 0}; n = 2; end
    endcase
  endtask

  function automatic out_t expected(input kind_t k, input int st, input bit fin, input bit ill);
    out_t o;
    o = '0;
    o.state   = st[2:0];
    o.illegal = ill;
    if (st == 0) o.ir_we = 1'b1;
    if (st == 2 || st == 3) begin
      case (k)
        K_SUBU, K_BEQ: o.alu_op = 2'd1;
        K_ORI:         begin o.alu_op = 2'd2; o.alu_src = 1'b1; end
        K_LW, K_SW:    begin o.alu_src = 1'b1; o.ext_op = 1'b1; end
        default: ;
      endcase
    end
    if (st == 3 && k == K_SW) o.mem_we = 1'b1;
    if (st == 4) begin
      o.reg_we = 1'b1;
      case (k)
        K_ADDU, K_SUBU: o.reg_dst = 2'd1;
        K_LW:           o.wd_sel  = 2'd1;
        K_LUI:          o.wd_sel  = 2'd3;
        K_JAL:          begin o.reg_dst = 2'd2; o.wd_sel = 2'd2; end
        default: ;
      endcase
    end
    if (fin) begin
      o.pc_we = 1'b1;
      case (k)
        K_J, K_JAL: o.npc_sel = 3'd3;
        K_JR:       o.npc_sel = 3'd2;
        K_BEQ:      o.npc_sel = 3'd1;
        default:    o.npc_sel = 3'd0;
      endcase
    end
    return o;
  endfunction

  function automatic logic [31:0] make_instr(input kind_t k);
    logic [31:0] r;
    logic [5:0]  op;
    logic [5:0]  fn;
    r = $urandom;
    case (k)
      K_ADDU: return {6'h00, r[25:6], 6'h21};
      K_SUBU: return {6'h00, r[25:6], 6'h23};
      K_JR:   return {6'h00, r[25:6], 6'h08};
      K_ORI:  return {6'h0D, r[25:0]};
      K_LUI:  return {6'h0F, r[25:0]};
      K_LW:   return {6'h23, r[25:0]};
      K_SW:   return {6'h2B, r[25:0]};
      K_BEQ:  return {6'h04, r[25:0]};
      K_J:    return {6'h02, r[25:0]};
      K_JAL:  return {6'h03, r[25:0]};
      K_NOP:  return 32'd0;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          op = 6'($urandom_range(1, 63));
          while (op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h0D ||
                 op == 6'h0F || op == 6'h23 || op == 6'h2B)
            op = 6'($urandom_range(1, 63));
          return {op, r[25:0]};
        end else begin
          fn = 6'($urandom_range(0, 63));
          while (fn == 6'h21 || fn == 6'h23 || fn == 6'h08)
            fn = 6'($urandom_range(0, 63));
          return {6'h00, r[25:12], 1'b1, r[10:6], fn};
        end
      end
    endcase
  endfunction

  // Single compare process: full output vector against the model each cycle
  always @(negedge clk) begin
    if (exp_valid) begin
      if (exp_rst) begin
        check("reset_no_writes", {29'd0, bus.pc_we, bus.reg_we, bus.mem_we}, 32'd0);
      end else begin
        check("cycle_model", 32'(dut_out()), 32'(exp_out));
`ifdef MC_CTRL_STATS_EN
        check("cycle_cnt_model", cycle_cnt, model_cyc);
        check("instret_cnt_model", instret_cnt, model_ret);
`endif
      end
    end
  end

  // Called at posedge+1 with the DUT in FETCH
  task automatic do_reset(input int ncyc);
    reset   = 1'b1;
    exp_rst = 1'b1;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
    end
    reset         = 1'b0;
    exp_rst       = 1'b0;
    model_illegal = 1'b0;
    model_cyc     = 0;
    model_ret     = 0;
  endtask

  // Runs one instruction from its FETCH cycle; abort_step asserts reset in that step
  task automatic applyStimulus(input logic [31:0] ins, input int abort_step, output out_t tr[5]);
    kind_t k;
    int    n;
    int    p[5];
    k = classify(ins);
    path_of(k, n, p);
    for (int i = 0; i < 5; i++) tr[i] = '0;
    bus.instr = ins;
    for (int s = 0; s < n; s++) begin
      exp_out   = expected(k, p[s], (s == n - 1), model_illegal);
      exp_valid = 1'b1;
      if (s == abort_step) begin
        reset   = 1'b1;
        exp_rst = 1'b1;
      end
      @(negedge clk);
      #1;
      tr[s] = dut_out();
      @(posedge clk);
      #1;
      if (s == abort_step) begin
        reset         = 1'b0;
        exp_rst       = 1'b0;
        model_illegal = 1'b0;
        model_cyc     = 0;
        model_ret     = 0;
        return;
      end
      model_cyc++;
      if (s == n - 1) model_ret++;
      if (p[s] == 1 && k == K_ILL) model_illegal = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    out_t  tr[5];
    out_t  rst_vec;
    kind_t k;
    int    ab;

    reset     = 1'b1;
    bus.instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // addu straight after reset; its FETCH cycle is also the post-reset state
    applyStimulus(32'h00851021, -1, tr);
    rst_vec       = '0;
    rst_vec.ir_we = 1'b1;
    checkOutput("after_reset_outputs", 32'(tr[0]), 32'(rst_vec));
    checkOutput("addu_states", {20'd0, tr[0].state, tr[1].state, tr[2].state, tr[3].state},
                {20'd0, 3'd0, 3'd1, 3'd2, 3'd4});
    checkOutput("addu_wb_ctrl", {tr[3].reg_we, tr[3].reg_dst, tr[3].wd_sel, tr[3].pc_we, tr[3].npc_sel},
                {1'b1, 2'd1, 2'd0, 1'b1, 3'd0});
    checkOutput("addu_retired", 32'(bus.state), 32'd0);

    applyStimulus(32'h8C850004, -1, tr);
    checkOutput("lw_states", {17'd0, tr[0].state, tr[1].state, tr[2].state, tr[3].state, tr[4].state},
                {17'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    checkOutput("lw_mem_ctrl", {tr[3].alu_src, tr[3].ext_op, tr[3].mem_we}, {1'b1, 1'b1, 1'b0});
    checkOutput("lw_wb_wd_sel", 32'(tr[4].wd_sel), 32'd1);

    applyStimulus(32'h0C000C00, -1, tr);
    checkOutput("jal_states", {23'd0, tr[0].state, tr[1].state, tr[2].state}, {23'd0, 3'd0, 3'd1, 3'd4});
    checkOutput("jal_wb_ctrl", {tr[2].reg_dst, tr[2].wd_sel, tr[2].npc_sel, tr[2].pc_we},
                {2'd2, 2'd2, 3'd3, 1'b1});
    checkOutput("jal_then_fetch", 32'(bus.state), 32'd0);

    applyStimulus(32'hAC850008, 3, tr);
    checkOutput("sw_reset_in_mem_state", 32'(tr[3].state), 32'd3);
    checkOutput("sw_reset_mem_we", 32'(tr[3].mem_we), 32'd0);
    checkOutput("sw_reset_to_fetch", 32'(bus.state), 32'd0);

    applyStimulus(32'hFC000000, -1, tr);
    checkOutput("illegal_low_in_decode", 32'(tr[1].illegal), 32'd0);
    checkOutput("illegal_set_after_decode", 32'(bus.illegal), 32'd1);
    checkOutput("illegal_retire_2cyc", 32'(bus.state), 32'd0);
    applyStimulus(32'h00851021, -1, tr);
    checkOutput("illegal_sticky", 32'(bus.illegal), 32'd1);
    do_reset(1);
    checkOutput("illegal_cleared_by_reset", 32'(bus.illegal), 32'd0);

`ifdef MC_CTRL_STATS_EN
    do_reset(1);
    applyStimulus(32'h08000000, -1, tr);
    applyStimulus(32'h10850003, -1, tr);
    applyStimulus(32'h8C850004, -1, tr);
    checkOutput("stats_instret", instret_cnt, 32'd3);
    checkOutput("stats_cycles", cycle_cnt, 32'd10);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) do_reset(int'($urandom_range(1, 2)));
      k  = kind_t'($urandom_range(0, 11));
      ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
      applyStimulus(make_instr(k), ab, tr);
    end

    exp_valid = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
